alu_regfile: RTL and testbench
==============================

Name: alu_regfile

Overview:
- Register file and writeback stage wrapped around the registered 8-bit ALU.
- Upstream role: supplies the ALU a/b operands through two combinational read ports.
- Downstream role: one cycle after an ALU op is issued, captures the ALU's registered result/cout/zero, writes the result to the destination register and optionally updates the carry/zero flag register.
- Also provides a direct load port (immediates/memory) and forwards the in-flight ALU result to the read ports.

Parameters:
- DATA_BITS, 8, register and data width; must match the ALU.
- ADDR_BITS, 4, register address width; 2**ADDR_BITS registers.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_addr_a  in  ADDR_BITS  read port A address.
- rd_addr_b  in  ADDR_BITS  read port B address.
- rd_data_a  out  DATA_BITS  read port A data; drives ALU a.
- rd_data_b  out  DATA_BITS  read port B data; drives ALU b.
- issue  in  1  an ALU op is sampled by the ALU at this rising edge.
- issue_dest  in  ADDR_BITS  destination register of the issued op.
- issue_setflags  in  1  the issued op updates carry/zero.
- alu_result  in  DATA_BITS  ALU registered result.
- alu_cout  in  1  ALU registered carry.
- alu_zero  in  1  ALU registered zero.
- ld_we  in  1  direct load write enable.
- ld_addr  in  ADDR_BITS  direct load address.
- ld_data  in  DATA_BITS  direct load data.
- flag_carry  out  1  registered carry flag.
- flag_zero  out  1  registered zero flag.
- wb_valid  out  1  an ALU writeback is occurring this cycle (= pend_valid).
- ld_collision  out  1  registered pulse: a load was dropped due to a same-address writeback.

Behaviour:
- Reset: asynchronous assertion clears immediately: all registers = 0, pend_valid = 0, pend_dest = 0, pend_setflags = 0, flag_carry = 0, flag_zero = 0, ld_collision = 0.
  - Reset mid-operation discards any pending writeback; no write occurs on the first edge after release.
- Pending stage, registered each edge:
  - pend_valid <= issue.
  - pend_dest <= issue_dest.
  - pend_setflags <= issue & issue_setflags.
- Writeback timing: issue high in cycle N means the ALU registers its result at the end of cycle N, so alu_* are valid during cycle N+1. pend_valid is high during N+1.
- At the edge ending N+1, when pend_valid = 1: reg[pend_dest] <= alu_result.
  - If pend_setflags = 1, also: flag_carry <= alu_cout and flag_zero <= alu_zero.
  - Otherwise the flags hold.
- Back-to-back issue every cycle is legal. The pending stage is overwritten every edge; each result is written exactly once, one cycle after its issue.
- Reads are combinational:
  - rd_data_x = alu_result if pend_valid and rd_addr_x == pend_dest (forwarding).
  - Otherwise rd_data_x = reg[rd_addr_x].
  - A direct load is not forwarded; the loaded value is visible the cycle after ld_we.
  - Both ports may read the same address.
- Load write: when ld_we = 1, reg[ld_addr] <= ld_data at the edge.
- Write conflict: if ld_we, pend_valid and ld_addr == pend_dest in the same cycle:
  - The ALU writeback wins and the load is dropped.
  - ld_collision = 1 for the following cycle only; otherwise ld_collision = 0.
  - Different addresses: both writes occur.
- Flags are affected only by writebacks with setflags, never by loads.
- Addresses wrap naturally within ADDR_BITS; there are no out-of-range cases.

Test Plan:
- Reset, then read all 16 addresses on both ports -> all 0. flag_carry = flag_zero = 0, wb_valid = 0.
- ld R1 = 0x05, ld R2 = 0x03 on consecutive cycles. Next cycle read A = R1, B = R2 -> rd_data_a = 0x05, rd_data_b = 0x03.
- Issue dest R3 with setflags, alu model returns 0x08, cout 0, zero 0 -> wb_valid is high the next cycle with forwarded rd_data_a(R3) = 0x08. The cycle after, R3 reads 0x08 from storage and flags are 0/0.
- Back-to-back issues R4 (0xFF, setflags) then R4 (0x00, cout 1, zero 1, setflags), with reads of R4 every cycle -> forwarded 0xFF, then forwarded 0x00, then stored 0x00. flag_carry = 1, flag_zero = 1.
- Issue R5 without setflags, result 0x00 / zero 1 -> R5 = 0x00 and the flags keep their previous values.
- ld R6 = 0xAA in the same cycle as an R6 writeback of 0x11 -> R6 = 0x11 and ld_collision pulses for one cycle. Repeat with ld to R7 instead -> both writes land and no pulse.
- Issue R8 (pending), then assert reset_n = 0 during the writeback cycle -> after release R8 = 0, flags = 0 and no late write occurs.

Source files
------------

// File: rtl/alu_regfile.sv
// alu_regfile
//   Register file and writeback stage that sits around the registered 8-bit ALU.
//   Two combinational read ports supply the ALU operands. The in-flight ALU
//   result is forwarded to them. One cycle after an op is issued, the
//   registered ALU result is written to the destination register. When the op
//   asked for it, the carry/zero flags are updated at the same time. A direct
//   load port writes immediates or memory data. If a load and a writeback
//   target the same register in the same cycle, the writeback wins and the
//   dropped load is reported by a one-cycle pulse.
//
//   Issue handshake: there is no back-pressure. When issue is high at a rising
//   edge, the ALU has accepted the op at that edge. Its registered outputs
//   (alu_result/alu_cout/alu_zero) are valid for the whole following cycle,
//   and wb_valid is high during that cycle.
//
// Ports
//   clk, reset_n                  clock (rising edge), async active-low reset
//   rd_addr_a/b, rd_data_a/b      combinational read ports (ALU a/b)
//   issue, issue_dest,
//   issue_setflags                op accepted by the ALU this edge
//   alu_result/cout/zero          ALU registered outputs (valid cycle N+1)
//   ld_we, ld_addr, ld_data       direct load port
//   flag_carry, flag_zero         registered flags
//   wb_valid                      writeback occurring this cycle
//   ld_collision                  load dropped last cycle (one-cycle pulse)
module alu_regfile #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [ADDR_BITS-1:0] rd_addr_a,
   input  logic [ADDR_BITS-1:0] rd_addr_b,
   output logic [DATA_BITS-1:0] rd_data_a,
   output logic [DATA_BITS-1:0] rd_data_b,
   input  logic                 issue,
   input  logic [ADDR_BITS-1:0] issue_dest,
   input  logic                 issue_setflags,
   input  logic [DATA_BITS-1:0] alu_result,
   input  logic                 alu_cout,
   input  logic                 alu_zero,
   input  logic                 ld_we,
   input  logic [ADDR_BITS-1:0] ld_addr,
   input  logic [DATA_BITS-1:0] ld_data,
   output logic                 flag_carry,
   output logic                 flag_zero,
   output logic                 wb_valid,
   output logic                 ld_collision
);

   localparam int NUM_REGS = 1 << ADDR_BITS;

   logic [DATA_BITS-1:0] regs_q [NUM_REGS];
   logic [DATA_BITS-1:0] regs_d [NUM_REGS];
   logic                 pend_valid_q, pend_valid_d;
   logic [ADDR_BITS-1:0] pend_dest_q, pend_dest_d;
   logic                 pend_setflags_q, pend_setflags_d;
   logic                 flag_carry_q, flag_carry_d;
   logic                 flag_zero_q, flag_zero_d;
   logic                 ld_collision_q, ld_collision_d;
   logic                 ld_conflict;

   // The load loses only when it targets the register being written back.
   assign ld_conflict = ld_we & pend_valid_q & (ld_addr == pend_dest_q);

   always_comb begin
      regs_d          = regs_q;
      flag_carry_d    = flag_carry_q;
      flag_zero_d     = flag_zero_q;
      // The pending stage is reloaded every edge, so an op never writes twice.
      pend_valid_d    = issue;
      pend_dest_d     = issue_dest;
      pend_setflags_d = issue & issue_setflags;
      ld_collision_d  = ld_conflict;

      if (ld_we && !ld_conflict) begin
         regs_d[ld_addr] = ld_data;
      end
      if (pend_valid_q) begin
         regs_d[pend_dest_q] = alu_result;
         if (pend_setflags_q) begin
            flag_carry_d = alu_cout;
            flag_zero_d  = alu_zero;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         pend_valid_q    <= 1'b0;
         pend_dest_q     <= '0;
         pend_setflags_q <= 1'b0;
         flag_carry_q    <= 1'b0;
         flag_zero_q     <= 1'b0;
         ld_collision_q  <= 1'b0;
      end else begin
         regs_q          <= regs_d;
         pend_valid_q    <= pend_valid_d;
         pend_dest_q     <= pend_dest_d;
         pend_setflags_q <= pend_setflags_d;
         flag_carry_q    <= flag_carry_d;
         flag_zero_q     <= flag_zero_d;
         ld_collision_q  <= ld_collision_d;
      end
   end

   // The in-flight result is forwarded so that a dependent op issued right
   // behind its producer sees the new value. Loads are not forwarded.
   always_comb begin
      rd_data_a = regs_q[rd_addr_a];
      rd_data_b = regs_q[rd_addr_b];
      if (pend_valid_q && (rd_addr_a == pend_dest_q)) begin
         rd_data_a = alu_result;
      end
      if (pend_valid_q && (rd_addr_b == pend_dest_q)) begin
         rd_data_b = alu_result;
      end
   end

   assign flag_carry   = flag_carry_q;
   assign flag_zero    = flag_zero_q;
   assign wb_valid     = pend_valid_q;
   assign ld_collision = ld_collision_q;

endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile
//   Directed steps followed by a randomized run. The bench plays the ALU.
//   Each issued op is held in a queue together with the result the ALU will
//   return. The register file is modelled as a plain array that takes the
//   architectural effects of loads and writebacks at each edge.
module tb_alu_regfile;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int NR = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;
   logic [DW-1:0] rd_data_a, rd_data_b;
   logic          issue = 1'b0;
   logic [AW-1:0] issue_dest = '0;
   logic          issue_setflags = 1'b0;
   logic [DW-1:0] alu_result = '0;
   logic          alu_cout = 1'b0, alu_zero = 1'b0;
   logic          ld_we = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic          flag_carry, flag_zero, wb_valid, ld_collision;

   alu_regfile #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rd_addr_a      (rd_addr_a),
      .rd_addr_b      (rd_addr_b),
      .rd_data_a      (rd_data_a),
      .rd_data_b      (rd_data_b),
      .issue          (issue),
      .issue_dest     (issue_dest),
      .issue_setflags (issue_setflags),
      .alu_result     (alu_result),
      .alu_cout       (alu_cout),
      .alu_zero       (alu_zero),
      .ld_we          (ld_we),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data),
      .flag_carry     (flag_carry),
      .flag_zero      (flag_zero),
      .wb_valid       (wb_valid),
      .ld_collision   (ld_collision)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] dest;
      logic          sf;
      logic [DW-1:0] res;
      logic          c;
      logic          z;
   } op_t;

   op_t           inflight[$];
   logic [DW-1:0] m_reg [NR];
   logic          m_c, m_z, m_coll;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_reg[i] = '0;
      m_c = 1'b0;
      m_z = 1'b0;
      m_coll = 1'b0;
      inflight.delete();
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (inflight.size() > 0 && inflight[0].dest == a) return inflight[0].res;
      return m_reg[a];
   endfunction

   // Apply one cycle's inputs at the falling edge, then check all outputs
   // against the model.
   task automatic drive(input logic iss, input logic [AW-1:0] idest, input logic isf,
                        input logic [DW-1:0] ires, input logic ic, input logic iz,
                        input logic lwe, input logic [AW-1:0] la, input logic [DW-1:0] ldv,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      op_t op;
      @(negedge clk);
      issue = iss; issue_dest = idest; issue_setflags = isf;
      ld_we = lwe; ld_addr = la; ld_data = ldv;
      rd_addr_a = ra; rd_addr_b = rb;
      if (inflight.size() > 0) begin
         alu_result = inflight[0].res; alu_cout = inflight[0].c; alu_zero = inflight[0].z;
      end else begin
         // No writeback this cycle: the ALU lines carry noise that must be ignored.
         alu_result = 8'($urandom); alu_cout = 1'($urandom); alu_zero = 1'($urandom);
      end
      op.dest = idest; op.sf = isf; op.res = ires; op.c = ic; op.z = iz;
      #1;
      check("rd_data_a", 32'(rd_data_a), 32'(exp_rd(ra)));
      check("rd_data_b", 32'(rd_data_b), 32'(exp_rd(rb)));
      check("flag_carry", 32'(flag_carry), 32'(m_c));
      check("flag_zero", 32'(flag_zero), 32'(m_z));
      check("wb_valid", 32'(wb_valid), 32'(inflight.size() > 0));
      check("ld_collision", 32'(ld_collision), 32'(m_coll));
      if (iss) inflight.push_back(op);
   endtask

   // Advance through the rising edge and apply its architectural effects.
   task automatic tick();
      logic coll;
      op_t  wb;
      bit   has_wb;
      @(posedge clk);
      has_wb = 1'b0;
      // Ops are pushed in drive(), so an op issued this cycle is at the back.
      if (inflight.size() > (issue ? 1 : 0)) begin
         wb = inflight.pop_front();
         has_wb = 1'b1;
      end
      coll = ld_we && has_wb && (wb.dest == ld_addr);
      if (ld_we && !coll) m_reg[ld_addr] = ld_data;
      if (has_wb) begin
         m_reg[wb.dest] = wb.res;
         if (wb.sf) begin
            m_c = wb.c;
            m_z = wb.z;
         end
      end
      m_coll = coll;
   endtask

   task automatic idle_read(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      drive(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, ra, rb);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_flag_carry", 32'(flag_carry), 32'd0);
      check("rst_flag_zero", 32'(flag_zero), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_ld_collision", 32'(ld_collision), 32'd0);
      reset_n = 1'b1;

      // All registers read zero after reset, on both ports.
      for (int i = 0; i < NR; i++) begin
         idle_read(4'(i), 4'(NR - 1 - i));
         check("rst_reg_a", 32'(rd_data_a), 32'd0);
         check("rst_reg_b", 32'(rd_data_b), 32'd0);
         tick();
      end

      // Loads, visible the following cycle.
      drive(0, 0, 0, 8'h00, 0, 0, 1, 4'd1, 8'h05, 0, 0); tick();
      drive(0, 0, 0, 8'h00, 0, 0, 1, 4'd2, 8'h03, 0, 0); tick();
      idle_read(4'd1, 4'd2);
      check("ld_r1", 32'(rd_data_a), 32'h05);
      check("ld_r2", 32'(rd_data_b), 32'h03);
      tick();

      // Single issue with setflags: forwarded, then stored.
      drive(1, 4'd3, 1, 8'h08, 0, 0, 0, 0, 8'h00, 4'd3, 4'd1); tick();
      idle_read(4'd3, 4'd3);
      check("fwd_r3", 32'(rd_data_a), 32'h08);
      check("wb_valid_r3", 32'(wb_valid), 32'd1);
      tick();
      idle_read(4'd3, 4'd0);
      check("stored_r3", 32'(rd_data_a), 32'h08);
      check("flags_r3", 32'({flag_carry, flag_zero}), 32'd0);
      tick();

      // Back-to-back issues to the same register.
      drive(1, 4'd4, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 4'd4, 4'd4); tick();
      drive(1, 4'd4, 1, 8'h00, 1, 1, 0, 0, 8'h00, 4'd4, 4'd4);
      check("fwd_r4_ff", 32'(rd_data_a), 32'hFF);
      tick();
      idle_read(4'd4, 4'd4);
      check("fwd_r4_00", 32'(rd_data_b), 32'h00);
      tick();
      idle_read(4'd4, 4'd3);
      check("stored_r4", 32'(rd_data_a), 32'h00);
      check("flags_r4", 32'({flag_carry, flag_zero}), 32'b11);
      tick();

      // Writeback without setflags leaves the flags alone.
      drive(1, 4'd5, 0, 8'h00, 0, 1, 0, 0, 8'h00, 4'd0, 4'd0); tick();
      idle_read(4'd5, 4'd0); tick();
      idle_read(4'd5, 4'd0);
      check("stored_r5", 32'(rd_data_a), 32'h00);
      check("flags_hold", 32'({flag_carry, flag_zero}), 32'b11);
      tick();

      // Same-address load loses to the writeback.
      drive(1, 4'd6, 0, 8'h11, 0, 0, 0, 0, 8'h00, 0, 0); tick();
      drive(0, 0, 0, 8'h00, 0, 0, 1, 4'd6, 8'hAA, 4'd6, 4'd6); tick();
      idle_read(4'd6, 4'd6);
      check("coll_r6", 32'(rd_data_a), 32'h11);
      check("coll_pulse", 32'(ld_collision), 32'd1);
      tick();
      idle_read(4'd6, 4'd6);
      check("coll_pulse_end", 32'(ld_collision), 32'd0);
      tick();

      // Different addresses: both writes land.
      drive(1, 4'd6, 0, 8'h33, 0, 0, 0, 0, 8'h00, 0, 0); tick();
      drive(0, 0, 0, 8'h00, 0, 0, 1, 4'd7, 8'h77, 4'd6, 4'd7); tick();
      idle_read(4'd6, 4'd7);
      check("nocoll_r6", 32'(rd_data_a), 32'h33);
      check("nocoll_r7", 32'(rd_data_b), 32'h77);
      check("nocoll_pulse", 32'(ld_collision), 32'd0);
      tick();

      // Reset during the writeback cycle discards the pending write.
      drive(1, 4'd8, 1, 8'h5A, 1, 0, 0, 0, 8'h00, 0, 0); tick();
      idle_read(4'd8, 4'd7);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_mid_r7", 32'(rd_data_b), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idle_read(4'd8, 4'd8);
      check("rst_r8", 32'(rd_data_a), 32'd0);
      tick();
      idle_read(4'd8, 4'd8);
      check("rst_r8_late", 32'(rd_data_a), 32'd0);
      check("rst_flags", 32'({flag_carry, flag_zero}), 32'd0);
      tick();

      // Randomized traffic; a narrow address window makes forwarding and
      // collisions frequent.
      for (int n = 0; n < 400; n++) begin
         logic [AW-1:0] wnd;
         wnd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'd3;
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 32'(wnd))), 1'($urandom),
               8'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 32'(wnd))), 8'($urandom),
               4'($urandom_range(0, 32'(wnd))), 4'($urandom_range(0, 15)));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
